// File: rtl/led_panel_scan_pkg.sv
// led_pkg: LED colour codes, panel geometry and the RED detector used by the panel scanner.
package led_pkg;
    typedef enum logic [1:0] {BLU, GRN, YEL, RED} LED_t;
    localparam int ROWS = 2;
    localparam int COLS = 4;
    typedef logic [15:0] PANEL_PACKED_t;

    function automatic logic HAS_RED(PANEL_PACKED_t panel);
        for (int i = 0; i < ROWS * COLS; i++)
            if (LED_t'(panel[2*i +: 2]) == RED) return 1'b1;
        return 1'b0;
    endfunction
endpackage

// File: rtl/led_panel_scan_if.sv
// led_panel_scan_if: whole-panel update handshake between producer and display.
interface led_panel_scan_if;
    import led_pkg::*;
    logic          UPD_VALID;
    logic          UPD_READY;
    PANEL_PACKED_t UPD_PANEL;
    modport master (output UPD_VALID, output UPD_PANEL, input UPD_READY);
    modport slave (input UPD_VALID, input UPD_PANEL, output UPD_READY);
endinterface

// File: rtl/led_panel_buf.sv
// led_panel_buf: pending/active double buffer with handshake, frame-boundary swap and RED alert counter.
module led_panel_buf
    import led_pkg::*;
#(
    parameter int ALERT_W = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    led_panel_scan_if.slave     upd,
    input  logic                i_idle,
    input  logic                i_swap,
`ifdef WALK_TEST_EN
    input  logic                i_walk,
`endif
    output PANEL_PACKED_t       o_active,
    output logic                o_xfer,
    output logic                o_danger,
    output logic [ALERT_W-1:0]  o_alerts
);
    PANEL_PACKED_t r_active, r_pending, w_active_n;
    logic r_pfull, r_ready, w_pfull_n;

`ifdef WALK_TEST_EN
    assign upd.UPD_READY = r_ready && !i_walk;
`else
    assign upd.UPD_READY = r_ready;
`endif
    assign o_xfer   = upd.UPD_VALID && upd.UPD_READY;
    assign o_active = r_active;

    // While idle an update goes straight to the active buffer; otherwise it waits in pending.
    always_comb begin
        w_active_n = (o_xfer && i_idle) ? upd.UPD_PANEL : (i_swap && r_pfull) ? r_pending : r_active;
        w_pfull_n  = (i_swap && r_pfull) ? 1'b0 : (o_xfer && !i_idle) ? 1'b1 : r_pfull;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_active  <= '0;
            r_pending <= '0;
            r_pfull   <= 1'b0;
            r_ready   <= 1'b1;
            o_danger  <= 1'b0;
            o_alerts  <= '0;
        end else begin
            r_active  <= w_active_n;
            r_pending <= (o_xfer && !i_idle) ? upd.UPD_PANEL : r_pending;
            r_pfull   <= w_pfull_n;
            r_ready   <= !w_pfull_n;
            o_danger  <= HAS_RED(w_active_n);
            if (o_xfer && HAS_RED(upd.UPD_PANEL) && o_alerts != '1)
                o_alerts <= o_alerts + 1'b1;
        end
    end
endmodule

// File: rtl/led_panel_scan.sv
// led_panel_scan: row-multiplexed 2x4 RYGB panel driver with tear-free buffer swap.
// Define WALK_TEST_EN to add the WALK_REQ-triggered single-RED walk test.
module led_panel_scan
    import led_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int ALERT_W      = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
`ifdef WALK_TEST_EN
    input  logic                WALK_REQ,
`endif
    led_panel_scan_if.slave     upd,
    output logic [1:0]          ROW_SEL,
    output logic [7:0]          COL_COLOR,
    output logic                DANGER,
    output logic [ALERT_W-1:0]  ALERTS,
    output logic                FRAME_DONE
);
    localparam int CW = $clog2(DWELL_CYCLES + BLANK_CYCLES + 1);
    localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DW = CW'(DWELL_CYCLES - 1);

`ifdef WALK_TEST_EN
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE, WALK} state_t;
`else
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
`endif

    state_t r_state, w_state_n;
    logic r_row, w_row_n, w_xfer, w_swap;
    logic [CW-1:0] r_cnt, w_cnt_n;
    PANEL_PACKED_t w_active, w_disp;

`ifdef WALK_TEST_EN
    logic r_walk, w_walk_n;
    logic [2:0] r_wpos, w_wpos_n;
    assign w_swap = FRAME_DONE && !r_walk;
    // Walk overlays the display only; the active buffer is left intact and reappears afterwards.
    assign w_disp = r_walk ? (16'h5555 | (16'h0003 << {r_wpos, 1'b0})) : w_active;
`else
    assign w_swap = FRAME_DONE;
    assign w_disp = w_active;
`endif

    led_panel_buf #(.ALERT_W(ALERT_W)) u_buf (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .upd      (upd),
        .i_idle   (r_state == IDLE),
        .i_swap   (w_swap),
`ifdef WALK_TEST_EN
        .i_walk   (r_walk),
`endif
        .o_active (w_active),
        .o_xfer   (w_xfer),
        .o_danger (DANGER),
        .o_alerts (ALERTS)
    );

    assign FRAME_DONE = (r_state == DRIVE) && r_row && (r_cnt == '0);
    assign ROW_SEL    = (r_state == DRIVE) ? {r_row, !r_row} : 2'b00;
    assign COL_COLOR  = (r_state == DRIVE) ? (r_row ? w_disp[15:8] : w_disp[7:0]) : 8'h00;

    always_comb begin
        w_state_n = r_state;
        w_row_n   = r_row;
        w_cnt_n   = r_cnt - 1'b1;
        case (r_state)
            IDLE:  if (w_xfer) begin w_state_n = BLANK; w_row_n = 1'b0; w_cnt_n = BL; end
            BLANK: if (r_cnt == '0) begin w_state_n = DRIVE; w_cnt_n = DW; end
            DRIVE: if (r_cnt == '0) begin w_state_n = BLANK; w_row_n = !r_row; w_cnt_n = BL; end
`ifdef WALK_TEST_EN
            WALK:  begin w_state_n = BLANK; w_row_n = 1'b0; w_cnt_n = BL; end
`endif
            default: w_state_n = IDLE;
        endcase
`ifdef WALK_TEST_EN
        w_walk_n = r_walk;
        w_wpos_n = r_wpos;
        if (FRAME_DONE && r_walk) begin
            w_wpos_n = r_wpos + 3'd1;
            w_walk_n = r_wpos != 3'd7;
        end
        if (WALK_REQ) begin
            w_state_n = WALK;
            w_walk_n  = 1'b1;
            w_wpos_n  = 3'd0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_row   <= 1'b0;
            r_cnt   <= '0;
`ifdef WALK_TEST_EN
            r_walk  <= 1'b0;
            r_wpos  <= 3'd0;
`endif
        end else begin
            r_state <= w_state_n;
            r_row   <= w_row_n;
            r_cnt   <= w_cnt_n;
`ifdef WALK_TEST_EN
            r_walk  <= w_walk_n;
            r_wpos  <= w_wpos_n;
`endif
        end
    end
endmodule

// File: tb/tb_led_panel_scan.sv
// tb_led_panel_scan: time-index model of the scanner checked every cycle, plus directed literal checks.
module tb_led_panel_scan;
    localparam int D  = 4;
    localparam int B  = 1;
    localparam int AW = 2;
    localparam int P  = 2 * (B + D);

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic [1:0] ROW_SEL;
    logic [7:0] COL_COLOR;
    logic DANGER;
    logic [AW-1:0] ALERTS;
    logic FRAME_DONE;
`ifdef WALK_TEST_EN
    logic walk_req = 1'b0;
`endif

    led_panel_scan_if u_if();

    led_panel_scan #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .ALERT_W(AW)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
`ifdef WALK_TEST_EN
        .WALK_REQ   (walk_req),
`endif
        .upd        (u_if),
        .ROW_SEL    (ROW_SEL),
        .COL_COLOR  (COL_COLOR),
        .DANGER     (DANGER),
        .ALERTS     (ALERTS),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_red(logic [15:0] p);
        for (int i = 0; i < 8; i++)
            if (p[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    // Model: m_t counts cycles since the first frame began; row/blank phase follows from m_t mod P.
    bit m_started = 1'b0;
    int m_t = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;
    bit m_pfull = 1'b0;
    int m_alerts = 0;

    always @(posedge CLK) begin
        if (!RESET_N) begin
            m_started = 1'b0;
            m_t = 0;
            m_active = '0;
            m_pending = '0;
            m_pfull = 1'b0;
            m_alerts = 0;
        end else begin
            bit xfer, fend;
            xfer = u_if.UPD_VALID && !m_pfull;
            fend = m_started && m_t == P - 1;
            if (xfer && has_red(u_if.UPD_PANEL) && m_alerts < (1 << AW) - 1) m_alerts++;
            if (!m_started) begin
                if (xfer) begin
                    m_active = u_if.UPD_PANEL;
                    m_started = 1'b1;
                    m_t = 0;
                end
            end else begin
                if (fend && m_pfull) begin
                    m_active = m_pending;
                    m_pfull = 1'b0;
                end else if (xfer) begin
                    m_pending = u_if.UPD_PANEL;
                    m_pfull = 1'b1;
                end
                m_t = (m_t + 1) % P;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            logic [1:0] e_rs;
            logic [7:0] e_col;
            e_rs = 2'b00;
            e_col = 8'h00;
            if (m_started && m_t >= B && m_t < B + D) begin
                e_rs = 2'b01;
                e_col = m_active[7:0];
            end else if (m_started && m_t >= 2 * B + D) begin
                e_rs = 2'b10;
                e_col = m_active[15:8];
            end
            chk("row_sel", 32'(ROW_SEL), 32'(e_rs));
            chk("col_color", 32'(COL_COLOR), 32'(e_col));
            chk("frame_done", 32'(FRAME_DONE), 32'(m_started && m_t == P - 1));
            chk("danger", 32'(DANGER), 32'(has_red(m_active)));
            chk("alerts", 32'(ALERTS), 32'(m_alerts));
            chk("upd_ready", 32'(u_if.UPD_READY), 32'(!m_pfull));
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_fd();
        int n = 0;
        while (FRAME_DONE !== 1'b1 && n < 4 * P) begin tick(); n++; end
        chk("wait_frame_done", 32'(FRAME_DONE), 32'd1);
    endtask

    task automatic wait_row(logic [1:0] rs);
        int n = 0;
        while (ROW_SEL !== rs && n < 4 * P) begin tick(); n++; end
        chk("wait_row", 32'(ROW_SEL), 32'(rs));
    endtask

    initial begin
        int n;
        u_if.UPD_VALID = 1'b0;
        u_if.UPD_PANEL = 16'h0000;
        repeat (2) tick();
        chk_en = 1'b1;
        chk("reset_row_sel", 32'(ROW_SEL), 32'd0);
        chk("reset_ready", 32'(u_if.UPD_READY), 32'd1);
        chk("reset_alerts", 32'(ALERTS), 32'd0);
        RESET_N = 1'b1;
        tick();

        // All-BLU panel from IDLE: row 0 appears two cycles after the transfer.
        u_if.UPD_VALID = 1'b1;
        u_if.UPD_PANEL = 16'h0000;
        tick();
        u_if.UPD_VALID = 1'b0;
        chk("blank_after_xfer", 32'(ROW_SEL), 32'd0);
        tick();
        chk("row0_cycle2", 32'(ROW_SEL), 32'h1);
        chk("row0_col", 32'(COL_COLOR), 32'h0);
        wait_fd();
        n = 0;
        do begin tick(); n++; end while (FRAME_DONE !== 1'b1 && n < 4 * P);
        chk("frame_period", n, 10);

        // RED at LED(1,3).
        u_if.UPD_VALID = 1'b1;
        u_if.UPD_PANEL = 16'hC000;
        tick();
        u_if.UPD_VALID = 1'b0;
        wait_fd();
        tick();
        chk("danger_after_swap", 32'(DANGER), 32'd1);
        chk("alerts_one", 32'(ALERTS), 32'd1);
        wait_row(2'b10);
        chk("row1_col_red", 32'(COL_COLOR), 32'hC0);

        // Back-to-back updates: second stalls until the swap frees pending.
        u_if.UPD_VALID = 1'b1;
        u_if.UPD_PANEL = 16'h5A5A;
        tick();
        chk("ready_low_after_first", 32'(u_if.UPD_READY), 32'd0);
        u_if.UPD_PANEL = 16'h00E4;
        wait_fd();
        tick();
        chk("ready_after_swap", 32'(u_if.UPD_READY), 32'd1);
        tick();
        chk("second_accepted", 32'(u_if.UPD_READY), 32'd0);
        chk("alerts_two", 32'(ALERTS), 32'd2);
        u_if.UPD_PANEL = 16'h0003;
        repeat (3 * P + 2) tick();
        chk("alerts_saturated", 32'(ALERTS), 32'd3);

        // Reset while a row is driven and pending is full.
        u_if.UPD_PANEL = 16'hFFFF;
        wait_row(2'b01);
        chk("pending_full_pre_reset", 32'(u_if.UPD_READY), 32'd0);
        RESET_N = 1'b0;
        u_if.UPD_VALID = 1'b0;
        tick();
        chk("rst_row_sel", 32'(ROW_SEL), 32'd0);
        chk("rst_col", 32'(COL_COLOR), 32'd0);
        chk("rst_danger", 32'(DANGER), 32'd0);
        chk("rst_alerts", 32'(ALERTS), 32'd0);
        chk("rst_ready", 32'(u_if.UPD_READY), 32'd1);
        RESET_N = 1'b1;
        repeat (2 * P) tick();
        chk("idle_after_reset", 32'(ROW_SEL), 32'd0);
        u_if.UPD_VALID = 1'b1;
        u_if.UPD_PANEL = 16'h0055;
        tick();
        u_if.UPD_VALID = 1'b0;
        tick();
        chk("restart_row0", 32'(COL_COLOR), 32'h55);
        repeat (2 * P) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
